caeco_scheduler: RTL and testbench
==================================

# caeco_scheduler

Arbiter and sequencer for the shared CAECO streaming core. Accepts jobs from two requesters, the CPU MMIO port and the debug module (DM), and grants the core to one owner per job. It buffers the owner's data words in a small FIFO and drives the core's valid/ready input stream. It captures the result, raises a completion interrupt, and aborts and resets the core on timeout.

## Interface
- `BASE_ADDR`, 32'hC000_0010: CPU register base. Offsets: +0 data push / result read, +1 control write, +3 status read.
- `FIFO_DEPTH`, 4: input FIFO entries. Must be a power of two, ≥2.
- `TIMEOUT`, 16'd4096: idle cycles allowed in RUN/WAIT_RES before abort.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_en`, `cpu_wen` in 1: CPU access strobe and write qualifier.
- `cpu_addr` in 32, `cpu_wdata` in 32: CPU address and write data.
- `cpu_rdata` out 32: registered read data.
- `dm_wen` in 1: DM data push, using `dm_wdata`.
- `dm_cmd` in 1: DM control write, using `dm_wdata`.
- `dm_wdata` in 32: DM payload.
- `dm_status` out 32: live status, same layout as the status register, no clear side effects.
- `core_din` out 32, `core_din_valid` out 1, `core_din_ready` in 1, `core_din_last` out 1: core input stream.
- `core_cmd` out 2, `core_en` out 1, `core_rstn` out 1: core configuration.
- `core_result` in 32, `core_result_valid` in 1: core result.
- `irq` out 1: one-cycle pulse on job completion.

## Operation
- **Control word** (CPU +1 or DM `dm_cmd`):
  - [1:0] cmd, [2] en, [4] run (drives `core_rstn`).
  - [3] last_arm: the next pushed word carries the last flag.
  - [5] start, [6] release.
- **Status word:**
  - [0] busy, [1] owner (0=CPU, 1=DM), [2] done, [3] fifo_full.
  - [4] err_reject_cpu, [5] err_reject_dm, [6] err_overflow, [7] err_timeout.
  - [10:8] fifo_count. Other bits 0.
- **IDLE state:**
  - A control write with start=1 grants ownership and latches cmd/en/run. State goes to RUN.
  - Non-start control writes and data pushes in IDLE are dropped. Each sets the requester's err_reject bit.
- **Arbitration:**
  - Simultaneous start from both requesters goes to the requester that was not the last owner (round-robin).
  - After reset, CPU wins.
  - The loser's start is dropped and sets its err_reject bit.
- **Non-owner access:** while owned, any non-owner control write or data push is dropped and sets err_reject for that requester.
- **Data push:**
  - The owner's word is byte-swapped into the FIFO as {w[23:16], w[31:24], w[7:0], w[15:8]}.
  - The last flag is taken from last_arm, and last_arm is cleared on that push.
  - A push while the FIFO is full is dropped and sets err_overflow.
- **RUN state:**
  - `core_din_valid` = FIFO not empty. A word pops when valid && `core_din_ready`.
  - When the popped word has last=1, state goes to WAIT_RES.
- **WAIT_RES state:** on `core_result_valid`, latch `core_result`, set done, pulse `irq`, release ownership, go to IDLE.
- **Release:** an owner control write with release=1 in RUN or WAIT_RES flushes the FIFO and returns to IDLE. No irq.
- **Timeout:**
  - The counter resets on every push, pop or result. It increments otherwise in RUN/WAIT_RES.
  - When the counter reaches TIMEOUT, state goes to ABORT: `core_rstn`=0 for 2 cycles, FIFO flushed, err_timeout set, then IDLE with run=0.
- **CPU reads:**
  - Reading +0 returns the result register.
  - Reading +3 returns status and clears bits 2 and 4–7 in the same cycle.
  - Other offsets read 0.
  - A sticky bit that sets in the same cycle as the clearing read stays set.

## Timing
- All outputs are registered except `core_din`, `core_din_last` and `core_din_valid`, which come from the FIFO head registers.
- **Reset values:**
  - All outputs 0, including `core_rstn`=0.
  - State IDLE, FIFO empty, status 0, last owner = DM (so CPU wins the first tie).
- **Latencies:**
  - Start accepted at edge N: busy, owner and core config are visible at N+1.
  - Push at edge N: `core_din_valid` at N+1.
  - `core_result_valid` at N: `irq`=1 and done=1 during N+1, state IDLE at N+1.
  - `cpu_rdata` is valid the cycle after the read strobe.
  - Push and pop in the same cycle are both performed, and the count is unchanged.
  - Release and push from the owner in the same cycle: release wins, and the push is dropped without error.
  - Start from a non-owner during ABORT: rejected.
- **Mid-operation `rst`:** immediate return to reset values, regardless of state.

## Structure
- Package `caeco_sched_pkg` holds:
  - state enum (IDLE, RUN, WAIT_RES, ABORT);
  - address offsets;
  - control/status bit-index constants;
  - the byte-swap function.
- Sub-module `caeco_sync_fifo`, of width 33 and depth FIFO_DEPTH:
  - ports: push, pop, flush, full, empty, count;
  - same reset style as the scheduler.

## Test plan
- **Normal job:**
  - Stimulus: CPU ctrl 0x35 (start, run, en, cmd=1), push 0x11223344, ctrl 0x1D (last_arm), push 0x55667788, core returns 0xCAFE0001.
  - Required response: `core_din` 0x22114433 then 0x66558877 with last=1; `irq` 1 cycle; read +0 = 0xCAFE0001; status read = 0x004, and a second status read = 0x000.
- **Simultaneous start:**
  - Stimulus: CPU and DM start in the same cycle after reset.
  - Required response: CPU owns; status bit 5 set; `dm_status`[1]=0.
  - Repeat after release: DM owns.
- **Overflow:**
  - Stimulus: with `core_din_ready`=0, push 5 words.
  - Required response: fifo_count=4, fifo_full=1, err_overflow=1; the fifth word never appears on `core_din`.
- **Timeout:**
  - Stimulus: start, push a last word, no result for TIMEOUT cycles.
  - Required response: `core_rstn` low exactly 2 cycles; err_timeout=1; busy=0; no `irq`.
- **Reject and reset:**
  - Stimulus: DM push while CPU owns; then `rst` asserted in WAIT_RES.
  - Required response: the DM word is absent and err_reject_dm=1; after `rst`, all outputs are 0 and `core_din_valid`=0.

Source files
------------

// File: rtl/caeco_sched_pkg.sv
// Shared types and constants for the CAECO scheduler: FSM states, register
// offsets, control/status bit positions and the input byte-swap.
package caeco_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_WAIT_RES,
    ST_ABORT
  } state_t;

  localparam logic [31:0] OFF_DATA   = 32'd0;
  localparam logic [31:0] OFF_CTRL   = 32'd1;
  localparam logic [31:0] OFF_STATUS = 32'd3;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_DM  = 1'b1;

  localparam int CTRL_EN      = 2;
  localparam int CTRL_LAST    = 3;
  localparam int CTRL_RUN     = 4;
  localparam int CTRL_START   = 5;
  localparam int CTRL_RELEASE = 6;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_OWNER   = 1;
  localparam int STAT_DONE    = 2;
  localparam int STAT_FULL    = 3;
  localparam int STAT_ERR_LSB = 4;
  localparam int STAT_CNT_LSB = 8;

  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[23:16], w[31:24], w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/caeco_sync_fifo.sv
// Single-clock FIFO with flush; the head entry is presented combinationally
// from the storage registers so the consumer sees it the cycle after a push.
module caeco_sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CNT_W = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is cleared on reset because the head word drives a
      // module output directly and must read as zero after reset.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/caeco_scheduler.sv
// Two-requester (CPU MMIO / debug module) arbiter and job sequencer for the
// shared CAECO streaming core, with input FIFO, result capture and timeout.
module caeco_scheduler
  import caeco_sched_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hC000_0010,
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] TIMEOUT    = 16'd4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en,
  input  logic        cpu_wen,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  input  logic        dm_wen,
  input  logic        dm_cmd,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_status,
  output logic [31:0] core_din,
  output logic        core_din_valid,
  input  logic        core_din_ready,
  output logic        core_din_last,
  output logic [1:0]  core_cmd,
  output logic        core_en,
  output logic        core_rstn,
  input  logic [31:0] core_result,
  input  logic        core_result_valid,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_t      state;
  logic        owner_q;      // current owner while busy, last owner while idle
  logic        last_arm_q, done_q, en_q, run_q, irq_q, abort_cnt_q;
  logic [1:0]  cmd_q;
  logic [3:0]  err_q;        // {timeout, overflow, reject_dm, reject_cpu}
  logic [15:0] timer_q;
  logic [31:0] result_q, rdata_q, status;

  logic [32:0]      fifo_dout;
  logic             fifo_full, fifo_empty, fifo_push, fifo_pop, fifo_flush;
  logic [CNT_W-1:0] fifo_count;

  logic cpu_rd, cpu_push, cpu_ctrl, rd_status, rd_result;
  logic owned, own_ctrl, own_push, do_release;
  logic cpu_start, dm_start, grant_cpu, grant_dm;
  logic result_hit, activity, timeout_hit, set_ovf, set_rej_cpu, set_rej_dm;
  logic [31:0] own_word;
  logic [4:0]  grant_cfg;
  logic [15:0] timer_inc;
  logic [3:0]  err_set;

  assign cpu_rd    = cpu_en && !cpu_wen;
  assign cpu_push  = cpu_en && cpu_wen && (cpu_addr == BASE_ADDR + OFF_DATA);
  assign cpu_ctrl  = cpu_en && cpu_wen && (cpu_addr == BASE_ADDR + OFF_CTRL);
  assign rd_status = cpu_rd && (cpu_addr == BASE_ADDR + OFF_STATUS);
  assign rd_result = cpu_rd && (cpu_addr == BASE_ADDR + OFF_DATA);

  assign owned      = (state == ST_RUN) || (state == ST_WAIT_RES);
  assign own_word   = (owner_q == OWNER_DM) ? dm_wdata : cpu_wdata;
  assign own_ctrl   = owned && ((owner_q == OWNER_DM) ? dm_cmd : cpu_ctrl);
  assign own_push   = owned && ((owner_q == OWNER_DM) ? dm_wen : cpu_push);
  assign do_release = own_ctrl && own_word[CTRL_RELEASE];

  // Round-robin on a tie: the requester that did not own last time wins.
  assign cpu_start = (state == ST_IDLE) && cpu_ctrl && cpu_wdata[CTRL_START];
  assign dm_start  = (state == ST_IDLE) && dm_cmd && dm_wdata[CTRL_START];
  assign grant_dm  = dm_start && (!cpu_start || owner_q == OWNER_CPU);
  assign grant_cpu = cpu_start && !grant_dm;
  assign grant_cfg = grant_dm ? dm_wdata[4:0] : cpu_wdata[4:0];

  assign fifo_push   = own_push && !do_release && !fifo_full;
  assign set_ovf     = own_push && !do_release && fifo_full;
  assign fifo_pop    = core_din_valid && core_din_ready;
  assign result_hit  = (state == ST_WAIT_RES) && core_result_valid && !do_release;
  assign activity    = fifo_push || fifo_pop || result_hit;
  assign timer_inc   = timer_q + 16'd1;
  assign timeout_hit = owned && !activity && !do_release && (timer_inc == TIMEOUT);
  assign fifo_flush  = do_release || timeout_hit;

  assign set_rej_cpu = ((state == ST_IDLE) && ((cpu_ctrl && !grant_cpu) || cpu_push)) ||
                       (((owned && owner_q == OWNER_DM) || state == ST_ABORT) && (cpu_ctrl || cpu_push));
  assign set_rej_dm  = ((state == ST_IDLE) && ((dm_cmd && !grant_dm) || dm_wen)) ||
                       (((owned && owner_q == OWNER_CPU) || state == ST_ABORT) && (dm_cmd || dm_wen));
  assign err_set     = {timeout_hit, set_ovf, set_rej_dm, set_rej_cpu};

  always_comb begin
    // NOTE: every combinational output gets a default first so no latch can form.
    status                         = '0;
    status[STAT_BUSY]              = (state != ST_IDLE);
    status[STAT_OWNER]             = (state != ST_IDLE) && owner_q;
    status[STAT_DONE]              = done_q;
    status[STAT_FULL]              = fifo_full;
    status[STAT_ERR_LSB +: 4]      = err_q;
    status[STAT_CNT_LSB +: 3]      = 3'(fifo_count);
  end

  caeco_sync_fifo #(.WIDTH(33), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .din   ({last_arm_q, byte_swap(own_word)}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      owner_q     <= OWNER_DM;
      last_arm_q  <= 1'b0;
      done_q      <= 1'b0;
      en_q        <= 1'b0;
      run_q       <= 1'b0;
      irq_q       <= 1'b0;
      abort_cnt_q <= 1'b0;
      cmd_q       <= '0;
      err_q       <= '0;
      timer_q     <= '0;
      result_q    <= '0;
      rdata_q     <= '0;
    end else begin
      irq_q <= 1'b0;
      // A sticky bit that sets during a clearing status read stays set.
      if (rd_status) begin
        done_q <= result_hit;
        err_q  <= err_set;
      end else begin
        done_q <= done_q | result_hit;
        err_q  <= err_q | err_set;
      end
      if (cpu_rd) rdata_q <= rd_status ? status : (rd_result ? result_q : '0);
      timer_q <= (!owned || activity) ? '0 : timer_inc;
      if (fifo_push) last_arm_q <= 1'b0;

      unique case (state)
        ST_IDLE: begin
          if (grant_cpu || grant_dm) begin
            owner_q    <= grant_dm;
            cmd_q      <= grant_cfg[1:0];
            en_q       <= grant_cfg[CTRL_EN];
            last_arm_q <= grant_cfg[CTRL_LAST];
            run_q      <= grant_cfg[CTRL_RUN];
            state      <= ST_RUN;
          end
        end
        ST_RUN, ST_WAIT_RES: begin
          if (do_release) begin
            state <= ST_IDLE;
          end else if (result_hit) begin
            result_q <= core_result;
            irq_q    <= 1'b1;
            state    <= ST_IDLE;
          end else if (timeout_hit) begin
            run_q       <= 1'b0;
            abort_cnt_q <= 1'b0;
            state       <= ST_ABORT;
          end else begin
            if (own_ctrl) begin
              cmd_q      <= own_word[1:0];
              en_q       <= own_word[CTRL_EN];
              last_arm_q <= own_word[CTRL_LAST];
              run_q      <= own_word[CTRL_RUN];
            end
            if (state == ST_RUN && fifo_pop && fifo_dout[32]) state <= ST_WAIT_RES;
          end
        end
        ST_ABORT: begin
          if (abort_cnt_q) state <= ST_IDLE;
          else abort_cnt_q <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_rdata      = rdata_q;
  assign dm_status      = status;
  assign core_din       = fifo_dout[31:0];
  assign core_din_last  = fifo_dout[32];
  assign core_din_valid = (state == ST_RUN) && !fifo_empty;
  assign core_cmd       = cmd_q;
  assign core_en        = en_q;
  assign core_rstn      = run_q;
  assign irq            = irq_q;

endmodule

// File: tb/tb_caeco_scheduler.sv
// Directed bench for caeco_scheduler: a per-cycle vector table for the normal
// job, plus hand-written sequences for tie-break, overflow, timeout and reset.
module tb_caeco_scheduler;

  localparam logic [31:0] BASE = 32'hC000_0010;
  localparam int          TO   = 4096;

  logic        clk, rst;
  logic        cpu_en, cpu_wen;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        dm_wen, dm_cmd;
  logic [31:0] dm_wdata, dm_status;
  logic [31:0] core_din;
  logic        core_din_valid, core_din_ready, core_din_last;
  logic [1:0]  core_cmd;
  logic        core_en, core_rstn;
  logic [31:0] core_result;
  logic        core_result_valid, irq;

  caeco_scheduler #(.BASE_ADDR(BASE), .FIFO_DEPTH(4), .TIMEOUT(16'(TO))) dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_en            (cpu_en),
    .cpu_wen           (cpu_wen),
    .cpu_addr          (cpu_addr),
    .cpu_wdata         (cpu_wdata),
    .cpu_rdata         (cpu_rdata),
    .dm_wen            (dm_wen),
    .dm_cmd            (dm_cmd),
    .dm_wdata          (dm_wdata),
    .dm_status         (dm_status),
    .core_din          (core_din),
    .core_din_valid    (core_din_valid),
    .core_din_ready    (core_din_ready),
    .core_din_last     (core_din_last),
    .core_cmd          (core_cmd),
    .core_en           (core_en),
    .core_rstn         (core_rstn),
    .core_result       (core_result),
    .core_result_valid (core_result_valid),
    .irq               (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef enum {OP_NOP, OP_CPU_W, OP_CPU_R, OP_DM_PUSH, OP_DM_CMD, OP_RESULT} op_e;
  typedef enum {CHK_DIN, CHK_VALID, CHK_IRQ, CHK_RDATA, CHK_DSTAT, CHK_CORE} chk_e;
  typedef struct {
    string       name;
    op_e         op;
    logic [1:0]  off;
    logic [31:0] data;
    chk_e        chk;
    logic [33:0] exp;
  } vec_t;

  vec_t        vecs [12];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] ovf_words [5];
  logic [31:0] ovf_swapped [4];

  task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cpu_en = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dm_wen = 1'b0; dm_cmd = 1'b0; dm_wdata = '0;
    core_result_valid = 1'b0; core_result = '0;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply(input op_e op, input logic [1:0] off, input logic [31:0] data);
    idle_inputs();
    case (op)
      OP_CPU_W:   begin cpu_en = 1'b1; cpu_wen = 1'b1; cpu_addr = BASE + 32'(off); cpu_wdata = data; end
      OP_CPU_R:   begin cpu_en = 1'b1; cpu_addr = BASE + 32'(off); end
      OP_DM_PUSH: begin dm_wen = 1'b1; dm_wdata = data; end
      OP_DM_CMD:  begin dm_cmd = 1'b1; dm_wdata = data; end
      OP_RESULT:  begin core_result_valid = 1'b1; core_result = data; end
      default: ;
    endcase
    cycle();
    idle_inputs();
  endtask

  function automatic logic [33:0] actual(input chk_e c);
    case (c)
      CHK_DIN:   return {core_din_valid, core_din_last, core_din};
      CHK_VALID: return {33'd0, core_din_valid};
      CHK_IRQ:   return {33'd0, irq};
      CHK_RDATA: return {2'b00, cpu_rdata};
      CHK_DSTAT: return {2'b00, dm_status};
      default:   return {30'd0, core_cmd, core_en, core_rstn};
    endcase
  endfunction

  task automatic do_reset();
    idle_inputs();
    core_din_ready = 1'b0;
    rst = 1'b1;
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    check(name, {33'd0, |{cpu_rdata, dm_status, core_din, core_din_valid, core_din_last,
                          core_cmd, core_en, core_rstn, irq}}, 34'd0);
  endtask

  initial begin
    int  n;
    logic irq_seen;

    vecs[0]  = '{"start_core_cfg",  OP_CPU_W,   2'd1, 32'h0000_0035, CHK_CORE,  34'h7};
    vecs[1]  = '{"start_busy",      OP_NOP,     2'd0, 32'h0,         CHK_DSTAT, 34'h001};
    vecs[2]  = '{"push1_din",       OP_CPU_W,   2'd0, 32'h1122_3344, CHK_DIN,   {2'b10, 32'h2211_4433}};
    vecs[3]  = '{"ctrl_last_arm",   OP_CPU_W,   2'd1, 32'h0000_001D, CHK_DSTAT, 34'h001};
    vecs[4]  = '{"push2_din_last",  OP_CPU_W,   2'd0, 32'h5566_7788, CHK_DIN,   {2'b11, 32'h6655_8877}};
    vecs[5]  = '{"wait_res_valid",  OP_NOP,     2'd0, 32'h0,         CHK_VALID, 34'h0};
    vecs[6]  = '{"result_irq",      OP_RESULT,  2'd0, 32'hCAFE_0001, CHK_IRQ,   34'h1};
    vecs[7]  = '{"irq_one_cycle",   OP_NOP,     2'd0, 32'h0,         CHK_IRQ,   34'h0};
    vecs[8]  = '{"read_result",     OP_CPU_R,   2'd0, 32'h0,         CHK_RDATA, 34'h0CAFE_0001};
    vecs[9]  = '{"read_status",     OP_CPU_R,   2'd3, 32'h0,         CHK_RDATA, 34'h004};
    vecs[10] = '{"read_status_clr", OP_CPU_R,   2'd3, 32'h0,         CHK_RDATA, 34'h000};
    vecs[11] = '{"dstat_after_clr", OP_NOP,     2'd0, 32'h0,         CHK_DSTAT, 34'h000};

    ovf_words   = '{32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4, 32'hD1D2_D3D4, 32'hE1E2_E3E4};
    ovf_swapped = '{32'hA2A1_A4A3, 32'hB2B1_B4B3, 32'hC2C1_C4C3, 32'hD2D1_D4D3};

    // Reset state
    do_reset();
    check_all_zero("reset_outputs");
    check("reset_dstat", {2'b00, dm_status}, 34'h0);

    // Normal job, one table row per cycle
    core_din_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].op, vecs[i].off, vecs[i].data);
      check(vecs[i].name, actual(vecs[i].chk), vecs[i].exp);
    end

    // Simultaneous start: CPU first after reset, then DM after release
    do_reset();
    cpu_en = 1'b1; cpu_wen = 1'b1; cpu_addr = BASE + 32'd1; cpu_wdata = 32'h35;
    dm_cmd = 1'b1; dm_wdata = 32'h35;
    cycle();
    idle_inputs();
    check("tie1_cpu_owns", {2'b00, dm_status}, 34'h021);
    apply(OP_CPU_W, 2'd1, 32'h40);
    check("tie1_release", {2'b00, dm_status}, 34'h020);
    cpu_en = 1'b1; cpu_wen = 1'b1; cpu_addr = BASE + 32'd1; cpu_wdata = 32'h35;
    dm_cmd = 1'b1; dm_wdata = 32'h35;
    cycle();
    idle_inputs();
    check("tie2_dm_owns", {2'b00, dm_status}, 34'h033);
    apply(OP_DM_CMD, 2'd0, 32'h40);
    check("tie2_release", {2'b00, dm_status}, 34'h030);

    // Overflow: five pushes into a stalled four-entry FIFO
    do_reset();
    apply(OP_CPU_W, 2'd1, 32'h35);
    for (int i = 0; i < 5; i++) apply(OP_CPU_W, 2'd0, ovf_words[i]);
    check("ovf_status", {2'b00, dm_status}, 34'h449);
    core_din_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("ovf_drain%0d", i), actual(CHK_DIN), {2'b10, ovf_swapped[i]});
      cycle();
    end
    check("ovf_fifth_absent", actual(CHK_VALID), 34'h0);
    apply(OP_CPU_W, 2'd1, 32'h40);

    // Timeout in WAIT_RES
    do_reset();
    core_din_ready = 1'b1;
    apply(OP_CPU_W, 2'd1, 32'h3D);
    apply(OP_CPU_W, 2'd0, 32'h1234_5678);
    n = 0;
    irq_seen = 1'b0;
    while (n < TO + 100) begin
      cycle();
      n++;
      if (irq) irq_seen = 1'b1;
      if (!core_rstn) break;
    end
    check("tmo_latency", 34'(n), 34'(TO + 1));
    check("tmo_no_irq", {33'd0, irq_seen}, 34'h0);
    check("tmo_abort1", {1'b0, core_rstn, dm_status}, 34'h081);
    cycle();
    check("tmo_abort2", {1'b0, core_rstn, dm_status}, 34'h081);
    cycle();
    check("tmo_idle", {1'b0, core_rstn | irq, dm_status}, 34'h080);

    // Non-owner reject, then reset while waiting for a result
    do_reset();
    apply(OP_CPU_W, 2'd1, 32'h35);
    apply(OP_DM_PUSH, 2'd0, 32'hDEAD_BEEF);
    check("rej_dm_status", {2'b00, dm_status}, 34'h021);
    apply(OP_CPU_W, 2'd1, 32'h1D);
    apply(OP_CPU_W, 2'd0, 32'h0A0B_0C0D);
    check("rej_dm_word_absent", actual(CHK_DIN), {2'b11, 32'h0B0A_0D0C});
    core_din_ready = 1'b1;
    cycle();
    check("rej_wait_res", actual(CHK_VALID), 34'h0);
    apply(OP_CPU_R, 2'd3, 32'h0);
    check("rej_read_status", actual(CHK_RDATA), 34'h021);
    rst = 1'b1;
    cycle();
    check_all_zero("midrst_outputs");
    rst = 1'b0;
    cycle();
    check("midrst_valid", actual(CHK_VALID), 34'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
